// File: rtl/io_tx_compressor.sv
// ============================================================================
//  Module      : io_tx_compressor
//  Description : Fetches words from RAM and emits them as run-length bytes,
//                scanning LSB first; runs never cross word boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_tx_compressor #(
   parameter int N      = 32,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       word_count,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [N-1:0]      mem_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              eob,
   output logic              busy,
   output logic              done
);

   localparam int C = $clog2(N) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_SCAN  = 3'd3;
   localparam logic [2:0] S_SEND  = 3'd4;
   localparam logic [2:0] S_FIN   = 3'd5;

   localparam logic [C-1:0] c_last_idx = C'(N - 1);
   localparam logic [C-1:0] c_full     = C'(N);

   logic [2:0]        r_state;
   logic [2:0]        w_next_state;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_words;
   logic [N-1:0]      r_shift;
   logic [C-1:0]      r_idx;
   logic [C-1:0]      r_run;
   logic [7:0]        r_tx_data;
   logic              r_eob;

   logic              w_run_end;
   logic              w_word_end;
   logic              w_last_word;
   logic [C-1:0]      w_run_len;

   // r_shift[0] is always the bit at r_idx; the word is shifted right as it is scanned
   assign w_run_end   = (r_idx == c_last_idx) || (r_shift[0] != r_shift[1]);
   assign w_word_end  = (r_idx == c_full);
   assign w_last_word = (r_words == 16'd1);
   assign w_run_len   = r_run + C'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = (word_count == 16'd0) ? S_FIN : S_FETCH;
         S_FETCH: w_next_state = S_WAIT;
         S_WAIT:  w_next_state = S_SCAN;
         S_SCAN:  if (w_run_end) w_next_state = S_SEND;
         S_SEND: begin
            if (tx_ready) begin
               if (!w_word_end)     w_next_state = S_SCAN;
               else if (w_last_word) w_next_state = S_FIN;
               else                  w_next_state = S_FETCH;
            end
         end
         S_FIN:   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      mem_rd   = 1'b0;
      tx_valid = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (r_state)
         S_IDLE:  busy     = 1'b0;
         S_FETCH: mem_rd   = 1'b1;
         S_SEND:  tx_valid = 1'b1;
         S_FIN:   done     = 1'b1;
         default: ;
      endcase
   end

   assign mem_addr = r_addr;
   assign tx_data  = r_tx_data;
   assign eob      = r_eob && (r_state == S_SEND);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr    <= '0;
         r_words   <= '0;
         r_shift   <= '0;
         r_idx     <= '0;
         r_run     <= '0;
         r_tx_data <= '0;
         r_eob     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_addr  <= base_addr;
                  r_words <= word_count;
               end
            end
            S_WAIT: begin
               r_shift <= mem_data;
               r_idx   <= '0;
               r_run   <= '0;
            end
            S_SCAN: begin
               r_shift <= r_shift >> 1;
               r_idx   <= r_idx + C'(1);
               if (w_run_end) begin
                  r_tx_data <= {r_shift[0], 7'd0} | 8'(w_run_len);
                  r_eob     <= (r_idx == c_last_idx) && w_last_word;
               end else begin
                  r_run <= w_run_len;
               end
            end
            S_SEND: begin
               if (tx_ready) begin
                  r_run <= '0;
                  if (w_word_end) begin
                     r_words <= r_words - 16'd1;
                     r_addr  <= r_addr + ADDR_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_io_tx_compressor.sv
// ============================================================================
//  Module      : tb_io_tx_compressor
//  Description : Directed bench for io_tx_compressor with a run-length model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_tx_compressor;

   localparam int N      = 32;
   localparam int ADDR_W = 20;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [15:0]       word_count = '0;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [N-1:0]      mem_data = '0;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready = 1'b1;
   logic              eob;
   logic              busy;
   logic              done;

   io_tx_compressor #(.N(N), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .word_count(word_count), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data(mem_data), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .eob(eob), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [N-1:0]      mem [int];
   logic [8:0]        exp_q[$];       // {eob, byte}
   logic [ADDR_W-1:0] exp_addr_q[$];
   int                first_len;
   int                n_xfer = 0;
   bit                have_prev = 0;
   logic [7:0]        prev_data;
   logic              prev_eob;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // RAM: data appears one cycle after the read strobe
   always @(posedge clk)
      mem_data <= (mem_rd && mem.exists(int'(mem_addr))) ? mem[int'(mem_addr)] : '0;

   // Expected bytes of a word: split into maximal runs of equal bits, LSB first
   task automatic add_word(input logic [N-1:0] w, input bit last);
      int i;
      int len;
      logic b;
      i = 0;
      while (i < N) begin
         b = w[i];
         len = 0;
         while (i < N) begin
            if (w[i] != b) break;
            len++;
            i++;
         end
         exp_q.push_back({last && (i == N), b, 7'(len)});
         if (first_len < 0) first_len = len;
      end
   endtask

   task automatic prep(input logic [ADDR_W-1:0] base, input int cnt,
                       input logic [N-1:0] w0, input logic [N-1:0] w1);
      logic [ADDR_W-1:0] a;
      first_len = -1;
      base_addr = base;
      word_count = 16'(cnt);
      for (int j = 0; j < cnt; j++) begin
         a = base + ADDR_W'(j);
         mem[int'(a)] = (j == 0) ? w0 : w1;
         exp_addr_q.push_back(a);
         add_word((j == 0) ? w0 : w1, j == cnt - 1);
      end
   endtask

   task automatic run_block(input int cnt, input int stall, input bit poke);
      int k;
      int first_valid;
      int done_k;
      int stall_left;
      first_valid = -1;
      done_k = -1;
      stall_left = stall;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (k = 1; k <= 3000; k++) begin
         if (poke) start = (k == 5);
         if (tx_valid && first_valid < 0) first_valid = k;
         if (tx_valid && stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
         end else begin
            tx_ready = 1'b1;
         end
         if (done) begin
            done_k = k;
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      tx_ready = 1'b1;
      chk("done_seen", (done_k > 0) ? 1 : 0, 1);
      chk("first_valid_cycle", first_valid, (cnt == 0) ? -1 : 3 + first_len);
      if (cnt == 0) chk("empty_done_cycle", done_k, 1);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("idle_after_block", busy, 0);
      chk("bytes_left", exp_q.size(), 0);
      chk("reads_left", exp_addr_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         have_prev = 0;
      end else begin
         if (mem_rd) begin
            if (exp_addr_q.size() == 0) chk("unexpected_mem_rd", 1, 0);
            else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
         end
         if (tx_valid) begin
            if (have_prev) begin
               chk("stall_tx_data", tx_data, prev_data);
               chk("stall_eob", eob, prev_eob);
            end
            if (tx_ready) begin
               logic [8:0] e;
               have_prev = 0;
               n_xfer++;
               if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("tx_data", tx_data, e[7:0]);
                  chk("eob", eob, e[8]);
               end
            end else begin
               have_prev = 1;
               prev_data = tx_data;
               prev_eob = eob;
            end
         end else begin
            have_prev = 0;
            chk("eob_without_valid", eob, 0);
         end
      end
   end

   initial begin
      int xfer0;
      bit hit;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_eob", eob, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_mem_addr", mem_addr, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // one all-zero word: single full-length run
      prep(20'd5, 1, 32'h0000_0000, 32'h0);
      chk("model_zero_count", exp_q.size(), 1);
      chk("model_zero_b0", exp_q[0], 9'h120);
      run_block(1, 0, 0);

      // half ones, half zeros
      prep(20'd0, 1, 32'h0000_FFFF, 32'h0);
      chk("model_half_count", exp_q.size(), 2);
      chk("model_half_b0", exp_q[0], 9'h090);
      chk("model_half_b1", exp_q[1], 9'h110);
      run_block(1, 0, 0);

      // two words, runs never merge across the boundary
      prep(20'd10, 2, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("model_two_count", exp_q.size(), 3);
      chk("model_two_b0", exp_q[0], 9'h0A0);
      chk("model_two_b1", exp_q[1], 9'h081);
      chk("model_two_b2", exp_q[2], 9'h11F);
      run_block(2, 0, 0);

      // back-pressure for 5 cycles, plus a start pulse while busy
      prep(20'd40, 1, 32'hF0F0_F0F0, 32'h0);
      run_block(1, 5, 1);

      // alternating bits and address wrap at the top of the RAM
      prep(20'hFFFFF, 2, 32'h5555_5555, 32'h8000_0000);
      run_block(2, 0, 0);

      // empty block
      prep(20'd3, 0, 32'h0, 32'h0);
      run_block(0, 0, 0);

      // reset while the second byte of 0x0000FFFF is being offered
      prep(20'd0, 1, 32'h0000_FFFF, 32'h0);
      xfer0 = n_xfer;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      hit = 0;
      for (int k = 0; k < 200; k++) begin
         if (tx_valid && n_xfer == xfer0 + 1) begin
            hit = 1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("reached_second_byte", hit, 1);
      reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_tx_valid", tx_valid, 0);
      chk("arst_eob", eob, 0);
      chk("arst_mem_rd", mem_rd, 0);
      chk("arst_tx_data", tx_data, 0);
      chk("arst_mem_addr", mem_addr, 0);
      exp_q.delete();
      exp_addr_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      prep(20'd30, 1, 32'hFFFF_FFFF, 32'h0);
      chk("model_ones_b0", exp_q[0], 9'h1A0);
      run_block(1, 0, 0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
